// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: debounced capture and hex decode of a time-multiplexed active-low 7-segment bus.
// Define SEG7_SCAN_DP_EN to also capture the decimal point (Seg_Dp in, Dp out).
module seg7_scan_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic [6:0]              Seg,
    input  logic [NUM_DIGITS-1:0]   Dig_Sel,
`ifdef SEG7_SCAN_DP_EN
    input  logic                    Seg_Dp,
    output logic [NUM_DIGITS-1:0]   Dp,
`endif
    output logic [4*NUM_DIGITS-1:0] Digits,
    output logic [NUM_DIGITS-1:0]   Valid,
    output logic [NUM_DIGITS-1:0]   Err,
    output logic                    Update,
    output logic [IW-1:0]           Update_Idx
);
`ifdef SEG7_SCAN_DP_EN
    localparam int SW = 8 + NUM_DIGITS;
    logic [SW-1:0] in_s;
    assign in_s = {Seg_Dp, Seg, Dig_Sel};
`else
    localparam int SW = 7 + NUM_DIGITS;
    logic [SW-1:0] in_s;
    assign in_s = {Seg, Dig_Sel};
`endif
    localparam logic [7:0] STB = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {IDLE, TRACK, HELD} state_t;

    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [SW-1:0]           s_q;
    logic [6:0]              seg_q;
    logic [NUM_DIGITS-1:0]   sel_q;
    logic                    eq, new_ok, commit, hit, blank;
    logic [3:0]              nib;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [NUM_DIGITS-1:0]   valid_q, err_q;
    logic                    upd_q;
    logic [IW-1:0]           idx_q;

    function automatic logic onehot(input logic [NUM_DIGITS-1:0] v);
        return (v != '0) && ((v & (v - NUM_DIGITS'(1))) == '0);
    endfunction

    assign seg_q = s_q[NUM_DIGITS +: 7];
    assign sel_q = s_q[NUM_DIGITS-1:0];

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            s_q     <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= in_s;
        end
    end

    // A changed sample restarts the run; IDLE waits for a one-hot select.
    always_comb begin
        eq      = (in_s == s_q);
        new_ok  = onehot(Dig_Sel);
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE || !eq) begin
            state_d = new_ok ? TRACK : IDLE;
            cnt_d   = new_ok ? 8'd1 : 8'd0;
        end else begin
            cnt_d   = (cnt_q == STB) ? cnt_q : cnt_q + 8'd1;
            state_d = commit ? HELD : state_q;
        end
    end

    always_comb begin
        commit = (state_q == TRACK) && (cnt_q == STB);
        blank  = (seg_q == 7'h7F);
        hit    = 1'b1;
        nib    = 4'h0;
        case (seg_q)
            7'h40: nib = 4'h0;
            7'h79: nib = 4'h1;
            7'h24: nib = 4'h2;
            7'h30: nib = 4'h3;
            7'h19: nib = 4'h4;
            7'h12: nib = 4'h5;
            7'h02: nib = 4'h6;
            7'h78: nib = 4'h7;
            7'h00: nib = 4'h8;
            7'h10: nib = 4'h9;
            7'h08: nib = 4'hA;
            7'h03: nib = 4'hB;
            7'h46: nib = 4'hC;
            7'h21: nib = 4'hD;
            7'h06: nib = 4'hE;
            7'h0E: nib = 4'hF;
            default: hit = 1'b0;
        endcase
        idx = '0;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (sel_q[k]) idx = IW'(k);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            digits_q <= '0;
            valid_q  <= '0;
            err_q    <= '0;
            upd_q    <= 1'b0;
            idx_q    <= '0;
        end else begin
            upd_q <= commit;
            if (commit) begin
                idx_q        <= idx;
                valid_q[idx] <= hit;
                err_q[idx]   <= !hit && !blank;
                if (hit) digits_q[{idx, 2'b00} +: 4] <= nib;
            end
        end
    end

`ifdef SEG7_SCAN_DP_EN
    logic [NUM_DIGITS-1:0] dp_q;
    always_ff @(posedge Clk) begin
        if (!Reset_n) dp_q <= '0;
        else if (commit) dp_q[idx] <= ~s_q[SW-1];
    end
    assign Dp = dp_q;
`endif

    assign Digits     = digits_q;
    assign Valid      = valid_q;
    assign Err        = err_q;
    assign Update     = upd_q;
    assign Update_Idx = idx_q;
endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture: directed checks of debounce latency, decode, blank/error and select faults.
module tb_seg7_scan_capture;
    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [6:0]  Seg = 7'h7F;
    logic [3:0]  Dig_Sel = 4'b0000;
    logic [15:0] Digits;
    logic [3:0]  Valid, Err;
    logic        Update;
    logic [1:0]  Update_Idx;
`ifdef SEG7_SCAN_DP_EN
    logic        Seg_Dp = 1'b1;
    logic [3:0]  Dp;
`endif
    int          checks = 0, errors = 0, n_upd = 0;
    logic [1:0]  idxq[$];

    always #5 Clk = ~Clk;

    seg7_scan_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Seg(Seg), .Dig_Sel(Dig_Sel),
`ifdef SEG7_SCAN_DP_EN
        .Seg_Dp(Seg_Dp), .Dp(Dp),
`endif
        .Digits(Digits), .Valid(Valid), .Err(Err),
        .Update(Update), .Update_Idx(Update_Idx)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
            if (Update) begin
                n_upd++;
                idxq.push_back(Update_Idx);
            end
        end
    endtask

    task automatic drive(input logic [6:0] s, input logic [3:0] d, input int n);
        Seg = s;
        Dig_Sel = d;
        tick(n);
    endtask

    initial begin
        Seg = 7'h40;
        Dig_Sel = 4'b0001;
        tick(2);
        chk("rst_digits", 32'(Digits), 32'h0);
        chk("rst_valid", 32'(Valid), 32'h0);
        chk("rst_err", 32'(Err), 32'h0);
        chk("rst_update", 32'(Update), 32'h0);
        chk("rst_idx", 32'(Update_Idx), 32'h0);

        Reset_n = 1'b1;
        n_upd = 0;
        tick(4);
        chk("early_update", 32'(n_upd), 32'd0);
        tick(1);
        chk("edge5_update", 32'(Update), 32'h1);
        chk("edge5_idx", 32'(Update_Idx), 32'h0);
        chk("edge5_d0", 32'(Digits[3:0]), 32'h0);
        chk("edge5_valid", 32'(Valid), 32'b0001);
        tick(1);
        chk("pulse_width", 32'(Update), 32'h0);
        n_upd = 0;
        tick(20);
        chk("held_no_recommit", 32'(n_upd), 32'd0);

        n_upd = 0;
        idxq.delete();
        drive(7'h79, 4'b0010, 3);
        chk("glitch_no_commit", 32'(n_upd), 32'd0);
        drive(7'h30, 4'b0010, 5);
        chk("glitch_n_upd", 32'(n_upd), 32'd1);
        chk("glitch_idx", 32'(idxq[0]), 32'd1);
        chk("glitch_d1", 32'(Digits[7:4]), 32'h3);
        chk("glitch_valid", 32'(Valid), 32'b0011);

        n_upd = 0;
        idxq.delete();
        drive(7'h79, 4'b1000, 8);
        drive(7'h08, 4'b0100, 8);
        drive(7'h30, 4'b0010, 8);
        drive(7'h0E, 4'b0001, 8);
        chk("scan_digits", 32'(Digits), 32'h1A3F);
        chk("scan_valid", 32'(Valid), 32'hF);
        chk("scan_err", 32'(Err), 32'h0);
        chk("scan_n_upd", 32'(n_upd), 32'd4);
        chk("scan_idx_seq", 32'({idxq[0], idxq[1], idxq[2], idxq[3]}), 32'b11_10_01_00);

        drive(7'h24, 4'b0100, 8);
        chk("d2_two", 32'(Digits[11:8]), 32'h2);
        chk("d2_valid", 32'(Valid[2]), 32'h1);
        drive(7'h7F, 4'b0100, 8);
        chk("blank_valid", 32'(Valid[2]), 32'h0);
        chk("blank_err", 32'(Err[2]), 32'h0);
        chk("blank_keep", 32'(Digits[11:8]), 32'h2);
        drive(7'h55, 4'b0100, 8);
        chk("illegal_err", 32'(Err), 32'b0100);
        chk("illegal_valid", 32'(Valid), 32'b1011);
        chk("illegal_keep", 32'(Digits), 32'h123F);

        n_upd = 0;
        drive(7'h00, 4'b0000, 10);
        drive(7'h00, 4'b0011, 10);
        chk("selfault_n_upd", 32'(n_upd), 32'd0);
        chk("selfault_digits", 32'(Digits), 32'h123F);
        chk("selfault_valid", 32'(Valid), 32'b1011);
        chk("selfault_err", 32'(Err), 32'b0100);

        n_upd = 0;
        drive(7'h00, 4'b0001, 3);
        Reset_n = 1'b0;
        tick(1);
        Reset_n = 1'b1;
        chk("midrst_n_upd", 32'(n_upd), 32'd0);
        chk("midrst_digits", 32'(Digits), 32'h0);
        chk("midrst_valid", 32'(Valid), 32'h0);
        chk("midrst_err", 32'(Err), 32'h0);
        tick(4);
        chk("restart_early", 32'(n_upd), 32'd0);
        tick(1);
        chk("restart_update", 32'(Update), 32'h1);
        chk("restart_digits", 32'(Digits), 32'h0008);
        chk("restart_valid", 32'(Valid), 32'b0001);

`ifdef SEG7_SCAN_DP_EN
        Seg_Dp = 1'b0;
        drive(7'h12, 4'b0001, 8);
        chk("dp_d0", 32'(Digits[3:0]), 32'h5);
        chk("dp_on", 32'(Dp[0]), 32'h1);
        n_upd = 0;
        Seg_Dp = 1'b1;
        tick(8);
        chk("dp_recommit", 32'(n_upd), 32'd1);
        chk("dp_off", 32'(Dp[0]), 32'h0);
        chk("dp_d0_keep", 32'(Digits[3:0]), 32'h5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Reader side of the board's 7-segment display path.
- Samples a time-multiplexed, active-low 7-segment bus and its one-hot digit-select lines.
- Requires each (segment, select) pair to be stable before committing it, then decodes the segment pattern back into a 4-bit hex value per digit.
- Used for self-check of display output and for capturing external display modules into the debug/register path.

Parameters:
- NUM_DIGITS, 4, number of digit-select lines and captured digits.
- STABLE_CYCLES, 4, consecutive identical samples required before commit (legal range 1..255).

Ports:
- Clk  input  1  system clock.
- Reset_n  input  1  synchronous, active-low reset.
- Seg  input  7  segment lines, active-low; Seg[0]=a … Seg[6]=g.
- Dig_Sel  input  NUM_DIGITS  digit select, active-high, expected one-hot.
- Digits  output  4*NUM_DIGITS  decoded nibbles; digit i occupies [4i+3:4i].
- Valid  output  NUM_DIGITS  digit i holds a legally decoded value.
- Err  output  NUM_DIGITS  last commit to digit i was an unrecognised pattern.
- Update  output  1  one-cycle pulse on each commit.
- Update_Idx  output  $clog2(NUM_DIGITS) (min 1)  digit index of the current Update pulse.

Behaviour:
- Reset: every edge with Reset_n=0 sets Digits=0, Valid=0, Err=0, Update=0, Update_Idx=0, sample register=all ones, run counter=0, FSM=IDLE. Reset asserted mid-run discards the partial run with no commit.
- Input stage: {Seg, Dig_Sel} is registered every edge into S. The run counter compares the new S with the previous S:
  - equal: increment, saturating at STABLE_CYCLES.
  - different: load 1.
- FSM:
  - IDLE: S select not exactly one-hot (zero or multi-hot). Counter held at 0, no commit. Exits to TRACK on the first one-hot S (counter=1).
  - TRACK: counting. When the counter reaches STABLE_CYCLES, commit and go to HELD.
  - HELD: pattern already committed. Any change in S goes to TRACK with counter=1, or to IDLE if the new select is not one-hot. No re-commit while S is unchanged.
- Latency:
  - Inputs stable from before edge 1 are committed at edge STABLE_CYCLES+1.
  - Update is high for exactly the cycle after that edge.
  - With STABLE_CYCLES=1, every new one-hot value commits two edges after it is presented.
- Commit to digit i (index of the set select bit):
  - Hex patterns (Seg value → nibble): 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9, 08→A, 03→B, 46→C, 21→D, 06→E, 0E→F (hex, 7-bit).
  - Matched pattern: nibble written, Valid[i]=1, Err[i]=0.
  - Blank (7F): Valid[i]=0, Err[i]=0, nibble retained.
  - Any other pattern: Valid[i]=0, Err[i]=1, nibble retained.
  - Other digits are unaffected.
- Update_Idx is valid only while Update=1. It holds its last value otherwise.

Optional Feature:
- Macro SEG7_SCAN_DP_EN.
- Defined:
  - Adds input Seg_Dp (1 bit, active-low) and output Dp (NUM_DIGITS bits, reset 0).
  - Seg_Dp is part of S and of the stability comparison.
  - Dp[i] is written as ~Seg_Dp on every commit to digit i, including blank and error commits.
- Undefined: neither port exists, and decimal-point activity has no effect.

Test Plan:
- Reset with Reset_n=0 for 2 edges while Seg=40, Dig_Sel=0001 → all outputs 0. Release, then hold Seg=40, Dig_Sel=0001 (STABLE_CYCLES=4) → Update=1 for one cycle after edge 5, Update_Idx=0, Digits[3:0]=0, Valid=0001; no further Update while held for 20 cycles.
- Glitch rejection: hold Seg=79 on digit 1 for 3 cycles, then 30 → no commit for 79. After 4 stable cycles of 30 → Digits[7:4]=3, Valid[1]=1.
- Scan "1A3F": cycle Dig_Sel 1000/0100/0010/0001 at 8 cycles each with 79/08/30/0E → Digits=16'h1A3F, Valid=1111, four Update pulses with indices 3,2,1,0.
- Illegal and blank: digit 2 gets 24 (→2), then 7F → Valid[2]=0, Err[2]=0, Digits[11:8]=2. Then 55 → Err[2]=1, Digits[11:8]=2.
- Select faults: Dig_Sel=0000 or 0011 held 10 cycles with Seg=00 → no Update, outputs unchanged. Reset_n pulsed at counter=3 → no commit, all outputs 0.
- SEG7_SCAN_DP_EN: Seg=12, Seg_Dp=0 on digit 0 → Digits[3:0]=5, Dp[0]=1. Toggling only Seg_Dp restarts the run and recommits with Dp[0]=0.
